// File: rtl/io_bus_arbiter_if.sv
// Signal bundle between the J1 I/O port, the second bus master (M2) and the peripherals.
// The arbiter connects through the slave modport and the CPU/M2/peripheral side through master.
interface io_bus_arbiter_if;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_dout;
  logic [15:0] cpu_din;
  logic        m2_req;
  logic        m2_we;
  logic [15:0] m2_addr;
  logic [15:0] m2_wdata;
  logic        m2_ack;
  logic        m2_err;
  logic [15:0] m2_rdata;
  logic        bus_rd;
  logic        bus_wr;
  logic [15:0] bus_addr;
  logic [15:0] bus_dout;
  logic [4:0]  cs;
  logic [79:0] per_rdata;
  logic [7:0]  conflict_cnt;
  logic        conflict_clr;

  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_dout,
    input  m2_req, m2_we, m2_addr, m2_wdata,
    input  per_rdata, conflict_clr,
    output cpu_din, m2_ack, m2_err, m2_rdata,
    output bus_rd, bus_wr, bus_addr, bus_dout, cs, conflict_cnt
  );

  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_dout,
    output m2_req, m2_we, m2_addr, m2_wdata,
    output per_rdata, conflict_clr,
    input  cpu_din, m2_ack, m2_err, m2_rdata,
    input  bus_rd, bus_wr, bus_addr, bus_dout, cs, conflict_cnt
  );
endinterface

// File: rtl/io_bus_arbiter.sv
// J1 peripheral bus arbiter: CPU has zero-latency ownership, M2 gets idle CPU slots.
// Also owns the page decode, chip selects and read-data return mux.
module io_bus_arbiter #(
  parameter int          MAX_WAIT   = 64,
  parameter logic [15:0] DEFAULT_RD = 16'h0666
) (
  input  logic             sys_clk_i,
  input  logic             sys_rst_i,
  io_bus_arbiter_if.slave  bus_if,
  output logic [1:0]       state_dbg
);

  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, PEND = 2'd1, DONE = 2'd2, ABORT = 2'd3} state_t;

  state_t      state;
  logic [WW-1:0] wait_cnt;
  logic [15:0] lat_addr;
  logic [15:0] lat_wdata;
  logic        lat_we;
  logic        m2_ack_q;
  logic        m2_err_q;
  logic [15:0] m2_rdata_q;
  logic [7:0]  conflict_q;

  logic        cpu_act;
  logic        bus_rd_w;
  logic        bus_wr_w;
  logic [15:0] bus_addr_w;
  logic [15:0] bus_dout_w;
  logic [4:0]  cs_w;
  logic [15:0] rd_mux;

  // Bus ownership: the CPU always wins; M2 drives only from PEND in a CPU-idle cycle.
  always_comb begin
    cpu_act    = bus_if.cpu_rd | bus_if.cpu_wr;
    bus_rd_w   = 1'b0;
    bus_wr_w   = 1'b0;
    bus_addr_w = bus_if.cpu_addr;
    bus_dout_w = bus_if.cpu_dout;
    if (cpu_act) begin
      bus_rd_w = bus_if.cpu_rd;
      bus_wr_w = bus_if.cpu_wr;
    end else if (state == PEND) begin
      bus_addr_w = lat_addr;
      bus_dout_w = lat_wdata;
      bus_wr_w   = lat_we;
      bus_rd_w   = ~lat_we;
    end
  end

  always_comb begin
    case (bus_addr_w[15:8])
      8'h67:               cs_w = 5'b00001;
      8'h68:               cs_w = 5'b00010;
      8'h69:               cs_w = 5'b00100;
      8'h70, 8'h71, 8'h72: cs_w = 5'b01000;
      8'h73:               cs_w = 5'b10000;
      default:             cs_w = 5'b00000;
    endcase
  end

  always_comb begin
    case (cs_w)
      5'b00001: rd_mux = bus_if.per_rdata[15:0];
      5'b00010: rd_mux = bus_if.per_rdata[31:16];
      5'b00100: rd_mux = bus_if.per_rdata[47:32];
      5'b01000: rd_mux = bus_if.per_rdata[63:48];
      5'b10000: rd_mux = bus_if.per_rdata[79:64];
      default:  rd_mux = DEFAULT_RD;
    endcase
  end

  // M2 handshake: m2_req is sampled only in IDLE; m2_ack is a one-cycle completion pulse
  // (with m2_err on abort), and M2 must drop m2_req in its ack cycle to avoid a repeat.
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_we     <= 1'b0;
      m2_ack_q   <= 1'b0;
      m2_err_q   <= 1'b0;
      m2_rdata_q <= '0;
      conflict_q <= '0;
    end else begin
      m2_ack_q <= 1'b0;
      m2_err_q <= 1'b0;
      if (bus_if.conflict_clr)
        conflict_q <= '0;
      else if (state == PEND && cpu_act && conflict_q != 8'hFF)
        conflict_q <= conflict_q + 8'd1;
      case (state)
        IDLE: begin
          if (bus_if.m2_req) begin
            lat_addr  <= bus_if.m2_addr;
            lat_wdata <= bus_if.m2_wdata;
            lat_we    <= bus_if.m2_we;
            wait_cnt  <= '0;
            state     <= PEND;
          end
        end
        PEND: begin
          if (!cpu_act) begin
            if (!lat_we) m2_rdata_q <= rd_mux;
            m2_ack_q <= 1'b1;
            state    <= DONE;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
            if (wait_cnt == WW'(MAX_WAIT - 1)) begin
              m2_ack_q <= 1'b1;
              m2_err_q <= 1'b1;
              state    <= ABORT;
            end
          end
        end
        DONE:    state <= IDLE;
        ABORT:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus_if.bus_rd       = bus_rd_w;
  assign bus_if.bus_wr       = bus_wr_w;
  assign bus_if.bus_addr     = bus_addr_w;
  assign bus_if.bus_dout     = bus_dout_w;
  assign bus_if.cs           = cs_w;
  assign bus_if.cpu_din      = rd_mux;
  assign bus_if.m2_ack       = m2_ack_q;
  assign bus_if.m2_err       = m2_err_q;
  assign bus_if.m2_rdata     = m2_rdata_q;
  assign bus_if.conflict_cnt = conflict_q;
  assign state_dbg           = state;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter: decode, CPU pass-through, M2 access, conflict abort and reset.
module tb_io_bus_arbiter;

  logic       sys_clk_i = 1'b0;
  logic       sys_rst_i = 1'b1;
  logic [1:0] state_dbg;
  int         n_assert = 0;
  int         n_fail   = 0;

  io_bus_arbiter_if bus_if ();

  io_bus_arbiter dut (
    .sys_clk_i (sys_clk_i),
    .sys_rst_i (sys_rst_i),
    .bus_if    (bus_if),
    .state_dbg (state_dbg)
  );

  always #5 sys_clk_i = ~sys_clk_i;

  // Move to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge sys_clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_idle();
    bus_if.cpu_rd   = 1'b0;
    bus_if.cpu_wr   = 1'b0;
  endtask

  logic [15:0] dec_addr [10];
  logic [4:0]  dec_cs   [10];
  logic [15:0] dec_dat  [10];

  initial begin
    dec_addr = '{16'h6700, 16'h6800, 16'h6900, 16'h7000, 16'h7100,
                 16'h7200, 16'h7300, 16'h6600, 16'h7400, 16'h0000};
    dec_cs   = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b01000,
                 5'b01000, 5'b10000, 5'b00000, 5'b00000, 5'b00000};
    dec_dat  = '{16'h1234, 16'h2222, 16'h3333, 16'hBEEF, 16'hBEEF,
                 16'hBEEF, 16'h00AA, 16'h0666, 16'h0666, 16'h0666};

    bus_if.cpu_rd       = 1'b0;
    bus_if.cpu_wr       = 1'b0;
    bus_if.cpu_addr     = 16'h0000;
    bus_if.cpu_dout     = 16'h0000;
    bus_if.m2_req       = 1'b0;
    bus_if.m2_we        = 1'b0;
    bus_if.m2_addr      = 16'h0000;
    bus_if.m2_wdata     = 16'h0000;
    bus_if.conflict_clr = 1'b0;
    bus_if.per_rdata    = {16'h00AA, 16'hBEEF, 16'h3333, 16'h2222, 16'h1234};

    // Reset
    step();
    step();
    sys_rst_i = 1'b0;
    #1;
    chk("rst_state", 32'(state_dbg), 32'd0);
    chk("rst_ack", 32'(bus_if.m2_ack), 32'd0);
    chk("rst_err", 32'(bus_if.m2_err), 32'd0);
    chk("rst_rdata", 32'(bus_if.m2_rdata), 32'h0);
    chk("rst_conflict", 32'(bus_if.conflict_cnt), 32'h0);
    chk("rst_bus_rd", 32'(bus_if.bus_rd), 32'd0);

    // Decode table with CPU idle: cs follows bus_addr without strobes
    for (int i = 0; i < 10; i++) begin
      bus_if.cpu_addr = dec_addr[i];
      #1;
      chk($sformatf("dec_cs_%0d", i), 32'(bus_if.cs), 32'(dec_cs[i]));
      chk($sformatf("dec_din_%0d", i), 32'(bus_if.cpu_din), 32'(dec_dat[i]));
    end

    // CPU read of 0x6702
    step();
    bus_if.cpu_rd   = 1'b1;
    bus_if.cpu_addr = 16'h6702;
    #1;
    chk("cpu_rd_cs", 32'(bus_if.cs), 32'b00001);
    chk("cpu_rd_din", 32'(bus_if.cpu_din), 32'h1234);
    chk("cpu_rd_strobe", 32'(bus_if.bus_rd), 32'd1);
    step();
    chk("cpu_rd_no_ack", 32'(bus_if.m2_ack), 32'd0);
    bus_if.cpu_addr = 16'h7300;
    #1;
    chk("cpu_rd73_cs", 32'(bus_if.cs), 32'b10000);
    chk("cpu_rd73_din", 32'(bus_if.cpu_din), 32'h00AA);
    cpu_idle();

    // M2 read 0x7010 with CPU idle
    step();
    bus_if.m2_req  = 1'b1;
    bus_if.m2_we   = 1'b0;
    bus_if.m2_addr = 16'h7010;
    step();
    bus_if.m2_req  = 1'b0;
    bus_if.m2_addr = 16'h1111;
    #1;
    chk("m2rd_bus_rd", 32'(bus_if.bus_rd), 32'd1);
    chk("m2rd_bus_wr", 32'(bus_if.bus_wr), 32'd0);
    chk("m2rd_addr", 32'(bus_if.bus_addr), 32'h7010);
    chk("m2rd_cs", 32'(bus_if.cs), 32'b01000);
    chk("m2rd_ack_early", 32'(bus_if.m2_ack), 32'd0);
    step();
    chk("m2rd_ack", 32'(bus_if.m2_ack), 32'd1);
    chk("m2rd_err", 32'(bus_if.m2_err), 32'd0);
    chk("m2rd_rdata", 32'(bus_if.m2_rdata), 32'hBEEF);
    chk("m2rd_no_strobe", 32'(bus_if.bus_rd), 32'd0);
    step();
    chk("m2rd_ack_pulse", 32'(bus_if.m2_ack), 32'd0);

    // M2 write 0x6900 blocked by 3 CPU write cycles
    bus_if.m2_req   = 1'b1;
    bus_if.m2_we    = 1'b1;
    bus_if.m2_addr  = 16'h6900;
    bus_if.m2_wdata = 16'h0041;
    for (int i = 0; i < 3; i++) begin
      step();
      bus_if.m2_req   = 1'b0;
      bus_if.cpu_wr   = 1'b1;
      bus_if.cpu_addr = 16'h6800 + 16'(i);
      bus_if.cpu_dout = 16'h1111;
      #1;
      chk($sformatf("blk_wr_%0d", i), 32'(bus_if.bus_wr), 32'd1);
      chk($sformatf("blk_addr_%0d", i), 32'(bus_if.bus_addr), 32'(16'h6800 + 16'(i)));
      chk($sformatf("blk_dout_%0d", i), 32'(bus_if.bus_dout), 32'h1111);
      chk($sformatf("blk_cs_%0d", i), 32'(bus_if.cs), 32'b00010);
    end
    step();
    cpu_idle();
    #1;
    chk("m2wr_bus_wr", 32'(bus_if.bus_wr), 32'd1);
    chk("m2wr_bus_rd", 32'(bus_if.bus_rd), 32'd0);
    chk("m2wr_addr", 32'(bus_if.bus_addr), 32'h6900);
    chk("m2wr_dout", 32'(bus_if.bus_dout), 32'h0041);
    chk("m2wr_cs", 32'(bus_if.cs), 32'b00100);
    chk("m2wr_conflict", 32'(bus_if.conflict_cnt), 32'd3);
    chk("m2wr_ack_early", 32'(bus_if.m2_ack), 32'd0);
    step();
    chk("m2wr_ack", 32'(bus_if.m2_ack), 32'd1);
    chk("m2wr_err", 32'(bus_if.m2_err), 32'd0);
    chk("m2wr_rdata_kept", 32'(bus_if.m2_rdata), 32'hBEEF);
    chk("m2wr_strobe_off", 32'(bus_if.bus_wr), 32'd0);

    // Clear, then abort after 64 blocked cycles
    step();
    bus_if.conflict_clr = 1'b1;
    step();
    bus_if.conflict_clr = 1'b0;
    chk("clr_conflict", 32'(bus_if.conflict_cnt), 32'd0);
    bus_if.m2_req   = 1'b1;
    bus_if.m2_we    = 1'b1;
    bus_if.m2_addr  = 16'h7200;
    bus_if.m2_wdata = 16'h5A5A;
    bus_if.cpu_rd   = 1'b1;
    bus_if.cpu_addr = 16'h6700;
    step();
    bus_if.m2_req = 1'b0;
    chk("abort_pend", 32'(state_dbg), 32'd1);
    for (int i = 0; i < 64; i++) begin
      #1;
      chk($sformatf("abort_nowr_%0d", i), 32'(bus_if.bus_wr), 32'd0);
      chk($sformatf("abort_addr_%0d", i), 32'(bus_if.bus_addr), 32'h6700);
      chk($sformatf("abort_noack_%0d", i), 32'(bus_if.m2_ack), 32'd0);
      step();
    end
    chk("abort_ack", 32'(bus_if.m2_ack), 32'd1);
    chk("abort_err", 32'(bus_if.m2_err), 32'd1);
    chk("abort_conflict", 32'(bus_if.conflict_cnt), 32'd64);
    chk("abort_rdata", 32'(bus_if.m2_rdata), 32'hBEEF);
    cpu_idle();
    step();
    chk("abort_done", 32'(bus_if.m2_ack), 32'd0);
    chk("abort_idle", 32'(state_dbg), 32'd0);

    // M2 read of unmapped page
    bus_if.m2_req  = 1'b1;
    bus_if.m2_we   = 1'b0;
    bus_if.m2_addr = 16'h5500;
    step();
    bus_if.m2_req = 1'b0;
    #1;
    chk("unm_cs", 32'(bus_if.cs), 32'd0);
    chk("unm_bus_rd", 32'(bus_if.bus_rd), 32'd1);
    step();
    chk("unm_ack", 32'(bus_if.m2_ack), 32'd1);
    chk("unm_err", 32'(bus_if.m2_err), 32'd0);
    chk("unm_rdata", 32'(bus_if.m2_rdata), 32'h0666);
    step();

    // Asynchronous reset while PEND drops the transaction
    bus_if.m2_req  = 1'b1;
    bus_if.m2_addr = 16'h6700;
    step();
    bus_if.m2_req = 1'b0;
    bus_if.cpu_wr = 1'b1;
    #1;
    chk("pre_rst_pend", 32'(state_dbg), 32'd1);
    #1;
    sys_rst_i = 1'b1;
    #1;
    chk("arst_state", 32'(state_dbg), 32'd0);
    chk("arst_rdata", 32'(bus_if.m2_rdata), 32'h0);
    chk("arst_conflict", 32'(bus_if.conflict_cnt), 32'd0);
    chk("arst_ack", 32'(bus_if.m2_ack), 32'd0);
    cpu_idle();
    #1;
    chk("arst_bus_rd", 32'(bus_if.bus_rd), 32'd0);
    step();
    sys_rst_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("post_rst_noack_%0d", i), 32'(bus_if.m2_ack), 32'd0);
    end

    // Saturation: back-to-back aborts with m2_req held high
    bus_if.m2_req   = 1'b1;
    bus_if.m2_we    = 1'b0;
    bus_if.cpu_rd   = 1'b1;
    bus_if.cpu_addr = 16'h6900;
    for (int i = 0; i < 300; i++) step();
    chk("sat_conflict", 32'(bus_if.conflict_cnt), 32'd255);
    begin
      int guard;
      guard = 0;
      while (state_dbg != 2'd1 && guard < 100) begin
        step();
        guard++;
      end
      chk("sat_wait_pend", 32'(guard < 100), 32'd1);
    end
    chk("sat_hold", 32'(bus_if.conflict_cnt), 32'd255);
    bus_if.conflict_clr = 1'b1;
    step();
    bus_if.conflict_clr = 1'b0;
    chk("sat_clr_prio", 32'(bus_if.conflict_cnt), 32'd0);
    bus_if.m2_req = 1'b0;
    cpu_idle();
    for (int i = 0; i < 70; i++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/io_bus_arbiter.md
Name: io_bus_arbiter

Overview:
- Shares the J1 peripheral I/O bus between the J1 CPU (primary master) and a second master (M2, e.g. a debug or DMA engine).
- Owns the page address decode, the chip-select generation and the read-data return mux for the peripherals: mult, div, uart, dp-RAM and motor control.
- The CPU path is zero-latency pass-through because the J1 cannot stall.
- M2 uses a req/ack handshake and is served only in cycles where the CPU is not accessing the bus.

Parameters:
- MAX_WAIT, 64, maximum cycles an M2 request may wait for a free bus slot before it is aborted with m2_err.
- DEFAULT_RD, 16'h0666, read data returned for unmapped pages.

Ports:
- sys_clk_i  in  1  system clock, all state on rising edge
- sys_rst_i  in  1  asynchronous active-high reset
- cpu_rd  in  1  J1 I/O read strobe
- cpu_wr  in  1  J1 I/O write strobe
- cpu_addr  in  16  J1 I/O address
- cpu_dout  in  16  J1 write data
- cpu_din  out  16  read data to J1 (combinational)
- m2_req  in  1  M2 request level
- m2_we  in  1  M2 direction: 1 = write, 0 = read
- m2_addr  in  16  M2 address
- m2_wdata  in  16  M2 write data
- m2_ack  out  1  one-cycle completion pulse
- m2_err  out  1  one-cycle abort pulse, coincident with m2_ack
- m2_rdata  out  16  registered M2 read data
- bus_rd  out  1  peripheral read strobe
- bus_wr  out  1  peripheral write strobe
- bus_addr  out  16  peripheral address
- bus_dout  out  16  peripheral write data
- cs  out  5  one-hot chip selects: [0] mult, [1] div, [2] uart, [3] dp-RAM, [4] motor
- per_rdata  in  80  peripheral read data, slice k*16 +: 16 belongs to cs[k]
- conflict_cnt  out  8  saturating count of cycles M2 was blocked by the CPU
- conflict_clr  in  1  synchronous clear of conflict_cnt

Behaviour:
- Reset values: state IDLE, m2_ack=0, m2_err=0, m2_rdata=0, conflict_cnt=0, wait counter=0, latched M2 registers=0.
- Reset mid-transaction drops the transaction with no ack.
- Address decode on bus_addr[15:8]:
  - 0x67 -> cs=00001
  - 0x68 -> cs=00010
  - 0x69 -> cs=00100
  - 0x70, 0x71, 0x72 -> cs=01000
  - 0x73 -> cs=10000
  - otherwise cs=00000
- cs is decoded from bus_addr regardless of strobes.
- Read mux: selected per_rdata slice; if cs=0 the result is DEFAULT_RD. cpu_din always equals this mux output (combinational).
- Bus owner:
  - If cpu_rd|cpu_wr: bus_* = CPU signals, combinational, same cycle.
  - Else if state==PEND: bus_addr/bus_dout = latched M2 registers, bus_wr = latched we, bus_rd = !latched we.
  - Else: bus_addr/bus_dout = CPU signals, bus_rd = bus_wr = 0.
- FSM states:
  - IDLE: if m2_req, latch m2_addr/m2_we/m2_wdata, clear wait counter -> PEND.
  - PEND, CPU idle this cycle: M2 access is driven; on a read, m2_rdata captures the mux output at the clock edge -> DONE.
  - PEND, CPU active: conflict_cnt +1 (saturates at 255); wait counter +1; when wait counter reaches MAX_WAIT -> ABORT, else stay in PEND.
  - DONE: m2_ack=1 -> IDLE.
  - ABORT: m2_ack=1, m2_err=1, m2_rdata unchanged, no bus access performed -> IDLE.
- Latency: m2_req high in cycle N with the CPU idle gives PEND in N+1 (access) and m2_ack in N+2. Minimum latency is 2 cycles.
- Inputs are sampled only in IDLE; M2 input changes while a transaction is pending are ignored.
- If m2_req is still high when returning to IDLE, a new transaction starts. M2 must drop m2_req in its ack cycle to avoid a repeat.
- M2 writes to unmapped pages complete normally with no effect; M2 reads from unmapped pages return DEFAULT_RD.
- conflict_clr has priority over increment in the same cycle.
- CPU timing and behaviour are never altered by M2 activity.

Test Plan:
- CPU read of 0x6702 with per_rdata[15:0]=0x1234 and M2 idle -> cs=00001, cpu_din=0x1234 in the same cycle; m2_ack stays 0.
- M2 read 0x7010 with the CPU idle and per_rdata[63:48]=0xBEEF -> bus_rd=1, cs=01000 in cycle N+1; m2_ack=1 and m2_rdata=0xBEEF in cycle N+2.
- M2 write 0x6900 data 0x0041 while the CPU writes for 3 consecutive cycles -> CPU owns the bus for those 3 cycles; M2 bus_wr appears on the 4th cycle; conflict_cnt=3; ack follows one cycle later.
- CPU continuously active for 64 cycles with an M2 request pending -> m2_ack=1 and m2_err=1 together; no M2 strobe ever driven; conflict_cnt=64.
- M2 read 0x5500 -> m2_rdata=0x0666, m2_err=0. Also: CPU read 0x7300 with slice 4 = 0x00AA -> cs=10000, cpu_din=0x00AA.
- Assert sys_rst_i asynchronously while in PEND -> all outputs return to reset values immediately; no m2_ack after release. conflict_cnt held at 255 with conflict_clr pulsed -> 0.
